// File: rtl/gb_result_unloader.sv
// Streams the accelerator's output region out of the global buffer, one line per read.
// A 2-entry FIFO with read credits absorbs sink back-pressure so no read data is lost.
module gb_result_unloader #(
  parameter int DATA_WIDTH            = 8,
  parameter int length                = 16,
  parameter int global_buf_addr_width = 17
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [12:0]                          N_SAMPLE,
  input  logic [12:0]                          OUTPUT_FEATURE_LENGTH,
  input  logic [global_buf_addr_width-1:0]     INIT_OUTPUT_ADDR,
  output logic                                 global_buf_read_external,
  output logic [global_buf_addr_width-1:0]     raddr_external,
  input  logic [DATA_WIDTH*length-1:0]         GB_rdata,
  output logic [DATA_WIDTH*length-1:0]         out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);
  localparam int LW = DATA_WIDTH * length;
  localparam int AW = global_buf_addr_width;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state, state_n;
  logic [21:0]     total, issued, accepted, prod;
  logic [AW-1:0]   base;
  logic            inflight;
  logic [LW-1:0]   mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic            params_ok, start_ok, pop, push, issue;
  logic [2:0]      occ;

  assign prod      = 22'(N_SAMPLE) * 22'(OUTPUT_FEATURE_LENGTH[12:4]);
  assign params_ok = (OUTPUT_FEATURE_LENGTH[3:0] == 4'd0) && (prod != 22'd0);
  assign start_ok  = start && (state == IDLE);

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Credit: lines buffered plus the read in flight, net of this cycle's pop, stay below 2.
  assign occ   = {1'b0, count} + {2'b0, inflight};
  assign issue = (state == RUN) && (issued != total) && (occ < ({2'b0, pop} + 3'd2));

  assign global_buf_read_external = issue;
  assign raddr_external = issue ? (base + issued[AW-1:0]) : '0;

  assign out_data = out_valid ? mem[rd_ptr] : '0;
  // FIFO is strictly in order, so the head line index is simply the accepted count.
  assign out_last = out_valid && (accepted == total - 22'd1);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:  if (start_ok && params_ok) state_n = RUN;
      RUN:   if (issued == total) state_n = DRAIN;
      DRAIN: if ((accepted + {21'b0, pop}) == total) state_n = FIN;
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      total    <= '0;
      base     <= '0;
      issued   <= '0;
      accepted <= '0;
      err      <= 1'b0;
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      state    <= state_n;
      inflight <= issue;
      if (start_ok) begin
        err <= !params_ok;
        if (params_ok) begin
          total    <= prod;
          base     <= INIT_OUTPUT_ADDR;
          issued   <= '0;
          accepted <= '0;
        end
      end else begin
        if (issue) issued <= issued + 22'd1;
        if (pop)   accepted <= accepted + 22'd1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= GB_rdata;
  end
endmodule

// File: doc/gb_result_unloader.md
# gb_result_unloader

Read-side counterpart to the external global-buffer load path. After the accelerator reports `done`, this block walks the output region of the global buffer line by line. It issues external read requests and streams each 128-bit result line off-chip over a valid/ready interface, flagging the last line. It sits between the `top` global-buffer external read port and the host/DMA sink, and it is flow-controlled so that no read data is lost under back-pressure.

## Interface
- `DATA_WIDTH`, 8, bits per element
- `length`, 16, elements per global-buffer line (line = `DATA_WIDTH*length` bits)
- `global_buf_addr_width`, 17, global-buffer address width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begin unload (ignored unless IDLE)
- `N_SAMPLE`  in  13  number of points
- `OUTPUT_FEATURE_LENGTH`  in  13  output channels per point; must be a nonzero multiple of `length`
- `INIT_OUTPUT_ADDR`  in  `global_buf_addr_width`  first line address of output region
- `global_buf_read_external`  out  1  read strobe to global buffer
- `raddr_external`  out  `global_buf_addr_width`  read address, valid with strobe
- `GB_rdata`  in  `DATA_WIDTH*length`  read data, valid exactly 1 cycle after strobe
- `out_data`  out  `DATA_WIDTH*length`  streamed line
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  sink accepts when high with `out_valid`
- `out_last`  out  1  qualifies final line of the unload
- `busy`  out  1  high from start acceptance until done pulse inclusive
- `done`  out  1  one-cycle pulse after final line accepted
- `err`  out  1  sticky parameter error; cleared by next accepted `start` or `rst`

## Operation
- Parameters are latched on `start`. `TOTAL = N_SAMPLE * (OUTPUT_FEATURE_LENGTH >> 4)` (22-bit unsigned product). The default configuration is 1024×64 → 4096 lines.
- Error: if `OUTPUT_FEATURE_LENGTH[3:0] != 0`, or `TOTAL == 0`, the block sets `err`, issues no reads, produces no `done`, and stays IDLE.
- States:
  - IDLE: on a valid `start`, go to RUN.
  - RUN: issue reads; once `issued == TOTAL`, go to DRAIN.
  - DRAIN: once `accepted == TOTAL`, go to FIN.
  - FIN: pulse `done` for one cycle, then go to IDLE.
- Address: `raddr_external = INIT_OUTPUT_ADDR + issued`, taken modulo 2^`global_buf_addr_width` (wraps silently).
- Buffering: a 2-entry output FIFO. `GB_rdata` is written into the FIFO in the cycle after a strobe; the FIFO head drives `out_data`.
- Credit rule: issue a read in a cycle iff `state == RUN` and `fifo_count + inflight - pop < 2`, where `pop = out_valid & out_ready` in that cycle. This guarantees no overflow and sustains 1 line/cycle with `out_ready` held high.
- `out_last` is high when the FIFO head is line index `TOTAL-1`.
- `start` while busy is ignored, with no effect on the counters.
- Simultaneous FIFO push and pop in one cycle: count unchanged, order preserved.

## Timing
- Reset values: `global_buf_read_external=0`, `raddr_external=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `busy=0`, `done=0`, `err=0`, FIFO empty, state IDLE.
- `rst` mid-unload aborts immediately: outputs return to reset values next cycle and any in-flight read data is discarded.
- Start sampled in cycle T:
  - first strobe in T+1;
  - data captured T+2;
  - `out_valid` high from T+3.
- With `out_ready` constant 1: one line per cycle. The last handshake occurs at T+2+TOTAL, and `done` is high in the following cycle; `busy` drops in the cycle after `done`.
- Back-pressure: `out_data`, `out_valid` and `out_last` hold stable while `out_valid & !out_ready`. At most 2 reads are outstanding or buffered at any time.

## Test plan
- Nominal: `INIT_OUTPUT_ADDR=0x10000`, N=1024, OFL=64, ready=1 → 4096 strobes at consecutive addresses 0x10000–0x10FFF, lines match memory image in order, `out_last` on line 4095 only, single `done` pulse, `done` at start+4099.
- Random back-pressure: ready toggling at 50% → same 4096 lines, no drops or duplicates, `fifo_count+inflight ≤ 2` every cycle, stable outputs while stalled.
- Long stall: ready=0 for 100 cycles after first valid → exactly 2 strobes issued, then none until ready rises; ordering intact.
- Wrap: `INIT_OUTPUT_ADDR=0x1FFFE`, N=1, OFL=64 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; `done` after 4th line.
- Errors/ignore: OFL=20 → `err=1`, no strobes, no `done`; next valid start clears `err`. N=0 → `err=1`. A `start` pulsed mid-RUN has no effect.
- Reset mid-run: assert `rst` after 10 lines → all outputs return to reset values next cycle; a fresh start replays from line 0.
